riscv_i32_dmem_access: RTL



---
 rtl/riscv_i32_dmem_access_if.sv | 55 +++++
 rtl/riscv_i32_dmem_access.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_i32_dmem_access_if.sv
// Bundle of the execute-side, data-memory and writeback signals of the
// data-memory access stage. The slave modport is the stage itself; the master
// modport is its environment (ALU stage, memory and register file together).
interface riscv_i32_dmem_access_if;
  // Instruction from the ALU stage
  logic        exec_valid;
  logic        exec_ready;
  logic        exec_is_load;
  logic        exec_is_store;
  logic [1:0]  exec_memory_width;
  logic        exec_memory_read_unsigned;
  logic [4:0]  exec_rd;
  logic        exec_rd_written;
  logic [31:0] exec_address;
  logic [31:0] exec_store_data;
  logic [31:0] exec_result;

  // Single-outstanding data-memory port
  logic        dmem_req;
  logic [31:0] dmem_address;
  logic        dmem_write_enable;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_ack;
  logic [31:0] dmem_read_data;

  // Writeback / trap report
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misaligned;
  logic [31:0] wb_misaligned_address;

  modport slave (
    input  exec_valid, exec_is_load, exec_is_store, exec_memory_width,
           exec_memory_read_unsigned, exec_rd, exec_rd_written,
           exec_address, exec_store_data, exec_result,
           dmem_ack, dmem_read_data,
    output exec_ready,
           dmem_req, dmem_address, dmem_write_enable, dmem_byte_enable,
           dmem_write_data,
           wb_valid, wb_rd, wb_data, wb_misaligned, wb_misaligned_address
  );

  modport master (
    output exec_valid, exec_is_load, exec_is_store, exec_memory_width,
           exec_memory_read_unsigned, exec_rd, exec_rd_written,
           exec_address, exec_store_data, exec_result,
           dmem_ack, dmem_read_data,
    input  exec_ready,
           dmem_req, dmem_address, dmem_write_enable, dmem_byte_enable,
           dmem_write_data,
           wb_valid, wb_rd, wb_data, wb_misaligned, wb_misaligned_address
  );
endinterface

// File: rtl/riscv_i32_dmem_access.sv
// Data-memory access stage behind the 32-bit integer ALU.
// Takes one executed instruction at a time, passes non-memory results straight
// to writeback, traps misaligned loads/stores without touching memory, and runs
// aligned accesses over a single-outstanding req/ack port. Load data is lane
// extracted and sign/zero extended before writeback.
module riscv_i32_dmem_access (
  input  logic                          clk,
  input  logic                          reset_n,
  riscv_i32_dmem_access_if.slave        bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] a);
    logic mis;
    case (width)
      WIDTH_BYTE: mis = 1'b0;
      WIDTH_HALF: mis = a[0];
      default:    mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte lanes touched by a store of the given width at byte offset a.
  function automatic logic [3:0] store_byte_enable(input logic [1:0] width,
                                                   input logic [1:0] a);
    logic [3:0] be;
    case (width)
      WIDTH_BYTE: be = 4'b0001 << a;
      WIDTH_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick the slot.
  function automatic logic [31:0] store_lane_data(input logic [1:0]  width,
                                                  input logic [31:0] d);
    logic [31:0] wd;
    case (width)
      WIDTH_BYTE: wd = {4{d[7:0]}};
      WIDTH_HALF: wd = {2{d[15:0]}};
      default:    wd = d;
    endcase
    return wd;
  endfunction

  // Select the addressed byte/half of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [1:0]  width,
                                               input logic [1:0]  a,
                                               input logic        zero_ext,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      WIDTH_BYTE: res = zero_ext ? {24'h000000, b} : {{24{b[7]}}, b};
      WIDTH_HALF: res = zero_ext ? {16'h0000, h}   : {{16{h[15]}}, h};
      default:    res = rdata;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state_r;
  logic [1:0]  addr_lo_r;
  logic [1:0]  width_r;
  logic        unsigned_r;
  logic [4:0]  rd_r;
  logic        rd_written_r;
  logic        is_load_r;

  logic        dmem_req_r;
  logic [31:0] dmem_address_r;
  logic        dmem_write_enable_r;
  logic [3:0]  dmem_byte_enable_r;
  logic [31:0] dmem_write_data_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_misaligned_r;
  logic [31:0] wb_misaligned_address_r;

  logic        accept_s;
  logic        is_mem_s;
  logic        misaligned_s;
  logic        rd_gate_s;
  logic [31:0] load_value_s;

  // Ready only while no memory access is outstanding.
  assign bus.exec_ready = (state_r == ST_IDLE);

  // Classify the presented instruction and precompute the load result.
  always_comb begin
    accept_s     = 1'b0;
    is_mem_s     = 1'b0;
    misaligned_s = 1'b0;
    rd_gate_s    = 1'b0;
    load_value_s = load_extract(width_r, addr_lo_r, unsigned_r, bus.dmem_read_data);
    if (bus.exec_valid && (state_r == ST_IDLE)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    is_mem_s = bus.exec_is_load | bus.exec_is_store;
    if (is_mem_s) begin
      misaligned_s = is_misaligned(bus.exec_memory_width, bus.exec_address[1:0]);
    end else begin
      misaligned_s = 1'b0;
    end
    rd_gate_s = bus.exec_rd_written && (bus.exec_rd != 5'd0);
  end

  // Accept/access sequencer with all outputs registered; wb pulses last one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r                 <= ST_IDLE;
      addr_lo_r               <= 2'b00;
      width_r                 <= 2'b00;
      unsigned_r              <= 1'b0;
      rd_r                    <= 5'd0;
      rd_written_r            <= 1'b0;
      is_load_r               <= 1'b0;
      dmem_req_r              <= 1'b0;
      dmem_address_r          <= 32'h0000_0000;
      dmem_write_enable_r     <= 1'b0;
      dmem_byte_enable_r      <= 4'h0;
      dmem_write_data_r       <= 32'h0000_0000;
      wb_valid_r              <= 1'b0;
      wb_rd_r                 <= 5'd0;
      wb_data_r               <= 32'h0000_0000;
      wb_misaligned_r         <= 1'b0;
      wb_misaligned_address_r <= 32'h0000_0000;
    end else begin
      wb_valid_r      <= 1'b0;
      wb_misaligned_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!is_mem_s) begin
              wb_data_r  <= bus.exec_result;
              wb_rd_r    <= bus.exec_rd;
              wb_valid_r <= rd_gate_s;
            end else if (misaligned_s) begin
              wb_misaligned_r         <= 1'b1;
              wb_misaligned_address_r <= bus.exec_address;
            end else begin
              addr_lo_r           <= bus.exec_address[1:0];
              width_r             <= bus.exec_memory_width;
              unsigned_r          <= bus.exec_memory_read_unsigned;
              rd_r                <= bus.exec_rd;
              rd_written_r        <= bus.exec_rd_written;
              is_load_r           <= bus.exec_is_load;
              dmem_req_r          <= 1'b1;
              dmem_address_r      <= {bus.exec_address[31:2], 2'b00};
              dmem_write_enable_r <= bus.exec_is_store;
              if (bus.exec_is_store) begin
                dmem_byte_enable_r <= store_byte_enable(bus.exec_memory_width,
                                                        bus.exec_address[1:0]);
                dmem_write_data_r  <= store_lane_data(bus.exec_memory_width,
                                                      bus.exec_store_data);
              end else begin
                dmem_byte_enable_r <= 4'hf;
                dmem_write_data_r  <= 32'h0000_0000;
              end
              state_r <= ST_ACCESS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (bus.dmem_ack) begin
            dmem_req_r <= 1'b0;
            state_r    <= ST_IDLE;
            if (is_load_r) begin
              wb_data_r  <= load_value_s;
              wb_rd_r    <= rd_r;
              wb_valid_r <= rd_written_r && (rd_r != 5'd0);
            end else begin
              wb_valid_r <= 1'b0;
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          dmem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dmem_req              = dmem_req_r;
  assign bus.dmem_address          = dmem_address_r;
  assign bus.dmem_write_enable     = dmem_write_enable_r;
  assign bus.dmem_byte_enable      = dmem_byte_enable_r;
  assign bus.dmem_write_data       = dmem_write_data_r;
  assign bus.wb_valid              = wb_valid_r;
  assign bus.wb_rd                 = wb_rd_r;
  assign bus.wb_data               = wb_data_r;
  assign bus.wb_misaligned         = wb_misaligned_r;
  assign bus.wb_misaligned_address = wb_misaligned_address_r;

endmodule
